// File: rtl/pcie_h2c_dsc_issuer_pkg.sv
// Shared types and constants for the H2C descriptor-bypass issuer and its stream path.
package pcie_h2c_dsc_issuer_pkg;

    localparam int DATA_W = 256;
    localparam int KEEP_W = 32;

    // XDMA descriptor control bit positions
    localparam int CTL_STOP_BIT      = 0;
    localparam int CTL_COMPLETED_BIT = 1;
    localparam int CTL_EOP_BIT       = 4;

    typedef logic [63:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } dsc_state_t;

    function automatic logic [5:0] keep_popcount(input logic [KEEP_W-1:0] keep);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + {5'd0, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pcie_h2c_dsc_issuer_skid.sv
// Two-entry AXI-Stream skid buffer with one cycle of input-to-output latency.
module axis_skid_256
    import pcie_h2c_dsc_issuer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready
);

    logic [DATA_W-1:0] data_q [2];
    logic [KEEP_W-1:0] keep_q [2];
    logic [1:0]        last_q;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_nxt;
    logic              ready_q;
    logic              push;
    logic              pop;

    assign push     = s_tvalid & ready_q;
    assign pop      = m_tvalid & m_tready;
    assign s_tready = ready_q;
    assign m_tvalid = (count != 2'd0);
    assign m_tdata  = data_q[rd_ptr];
    assign m_tkeep  = keep_q[rd_ptr];
    assign m_tlast  = last_q[rd_ptr] & m_tvalid;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (pop && !push) begin
            count_nxt = count - 2'd1;
        end else begin
            count_nxt = count;
        end
    end

    // Storage, pointers and registered ready (low through reset)
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                keep_q[i] <= '0;
            end
            last_q  <= 2'b00;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= s_tdata;
                keep_q[wr_ptr] <= s_tkeep;
                last_q[wr_ptr] <= s_tlast;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count   <= count_nxt;
            ready_q <= (count_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/pcie_h2c_dsc_issuer.sv
// Issues fixed-length H2C bypass descriptors over a slot ring and forwards the returned stream,
// tracking outstanding descriptors and flagging packets whose length differs from a slot.
module pcie_h2c_dsc_issuer
    import pcie_h2c_dsc_issuer_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR       = 64'h0000_0001_0000_0000,
    parameter logic [27:0] SLOT_LEN        = 28'h000_1000,
    parameter int          NR_SLOTS        = 16,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [15:0] DSC_CTL         = 16'h0010
) (
    input  logic              user_clk_250,
    input  logic              user_reset,
    input  logic              enable,
    output logic [63:0]       dsc_byp_src_addr,
    output logic [63:0]       dsc_byp_dst_addr,
    output logic [27:0]       dsc_byp_len,
    output logic [15:0]       dsc_byp_ctl,
    output logic              dsc_byp_load,
    input  logic              dsc_byp_ready,
    input  logic [DATA_W-1:0] s_h2c_tdata,
    input  logic [KEEP_W-1:0] s_h2c_tkeep,
    input  logic              s_h2c_tlast,
    input  logic              s_h2c_tvalid,
    output logic              s_h2c_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [31:0]       nr_issued,
    output logic [31:0]       nr_completed,
    output logic              len_err
);

    localparam int SLOT_W = (NR_SLOTS > 1) ? $clog2(NR_SLOTS) : 1;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NR_SLOTS - 1);
    localparam logic [OUT_W-1:0]  MAX_OUT   = OUT_W'(MAX_OUTSTANDING);

    dsc_state_t        state;
    logic              load_r;
    logic [SLOT_W-1:0] slot_r;
    logic [SLOT_W-1:0] slot_nxt;
    addr_t             addr_r;
    logic [OUT_W-1:0]  outstanding_r;
    logic [OUT_W-1:0]  outstanding_nxt;
    logic [31:0]       byte_cnt_r;
    logic [31:0]       pkt_total;
    logic [31:0]       nr_issued_r;
    logic [31:0]       nr_completed_r;
    logic              len_err_r;
    logic              accept;
    logic              complete;
    logic              in_hs;
    logic              can_issue;

    assign accept    = load_r & dsc_byp_ready;
    assign complete  = m_tvalid & m_tready & m_tlast;
    assign in_hs     = s_h2c_tvalid & s_h2c_tready;
    assign can_issue = enable & (outstanding_r < MAX_OUT);
    assign slot_nxt  = (slot_r == LAST_SLOT) ? {SLOT_W{1'b0}} : slot_r + SLOT_W'(1);
    assign pkt_total = byte_cnt_r + {26'd0, keep_popcount(s_h2c_tkeep)};

    assign dsc_byp_src_addr = addr_r;
    assign dsc_byp_dst_addr = 64'd0;
    assign dsc_byp_len      = SLOT_LEN;
    assign dsc_byp_ctl      = DSC_CTL;
    assign dsc_byp_load     = load_r;
    assign nr_issued        = nr_issued_r;
    assign nr_completed     = nr_completed_r;
    assign len_err          = len_err_r;

    // Simultaneous accept and completion cancel; never underflow on an orphan completion
    always_comb begin
        outstanding_nxt = outstanding_r;
        if (accept && !complete) begin
            outstanding_nxt = outstanding_r + OUT_W'(1);
        end else if (complete && !accept && (outstanding_r != {OUT_W{1'b0}})) begin
            outstanding_nxt = outstanding_r - OUT_W'(1);
        end else begin
            outstanding_nxt = outstanding_r;
        end
    end

    // Descriptor FSM; load and address are held until the engine accepts
    always_ff @(posedge user_clk_250) begin
        if (user_reset) begin
            state  <= ST_IDLE;
            load_r <= 1'b0;
            slot_r <= {SLOT_W{1'b0}};
            addr_r <= BASE_ADDR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (can_issue) begin
                        state  <= ST_ISSUE;
                        load_r <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (accept) begin
                        state  <= ST_WAIT;
                        load_r <= 1'b0;
                        slot_r <= slot_nxt;
                        addr_r <= BASE_ADDR + addr_t'(slot_nxt) * addr_t'(SLOT_LEN);
                    end
                end
                ST_WAIT: begin
                    state  <= can_issue ? ST_ISSUE : ST_IDLE;
                    load_r <= can_issue;
                end
                default: begin
                    state  <= ST_IDLE;
                    load_r <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding tracking, statistics and per-packet length checking
    always_ff @(posedge user_clk_250) begin
        if (user_reset) begin
            outstanding_r  <= {OUT_W{1'b0}};
            byte_cnt_r     <= 32'd0;
            nr_issued_r    <= 32'd0;
            nr_completed_r <= 32'd0;
            len_err_r      <= 1'b0;
        end else begin
            outstanding_r <= outstanding_nxt;
            if (accept) begin
                nr_issued_r <= nr_issued_r + 32'd1;
            end
            if (complete) begin
                nr_completed_r <= nr_completed_r + 32'd1;
            end
            if (in_hs) begin
                byte_cnt_r <= s_h2c_tlast ? 32'd0 : pkt_total;
                if (s_h2c_tlast && ((pkt_total != {4'd0, SLOT_LEN}) || (outstanding_r == {OUT_W{1'b0}}))) begin
                    len_err_r <= 1'b1;
                end
            end
        end
    end

    axis_skid_256 u_skid (
        .clk      (user_clk_250),
        .reset    (user_reset),
        .s_tdata  (s_h2c_tdata),
        .s_tkeep  (s_h2c_tkeep),
        .s_tlast  (s_h2c_tlast),
        .s_tvalid (s_h2c_tvalid),
        .s_tready (s_h2c_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
    );

endmodule

// File: tb/tb_pcie_h2c_dsc_issuer.sv
// Directed self-checking bench for pcie_h2c_dsc_issuer: descriptor issue, ring wrap,
// hold-off, length errors, stream back-pressure and mid-packet reset.
module tb_pcie_h2c_dsc_issuer;

    localparam logic [63:0] BASE = 64'h0000_0001_0000_0000;

    logic         clk = 1'b0;
    logic         user_reset;
    logic         enable;
    logic [63:0]  dsc_byp_src_addr;
    logic [63:0]  dsc_byp_dst_addr;
    logic [27:0]  dsc_byp_len;
    logic [15:0]  dsc_byp_ctl;
    logic         dsc_byp_load;
    logic         dsc_byp_ready;
    logic [255:0] s_h2c_tdata;
    logic [31:0]  s_h2c_tkeep;
    logic         s_h2c_tlast;
    logic         s_h2c_tvalid;
    logic         s_h2c_tready;
    logic [255:0] m_tdata;
    logic [31:0]  m_tkeep;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready;
    logic [31:0]  nr_issued;
    logic [31:0]  nr_completed;
    logic         len_err;

    int n_tests = 0;
    int n_fail  = 0;
    int in_cnt  = 0;
    int out_cnt = 0;
    int stalls  = 0;
    logic bp_mode = 1'b0;

    logic [63:0]  acc_q [$];
    logic [255:0] exp_data_q [$];
    logic [31:0]  exp_keep_q [$];
    logic         exp_last_q [$];
    logic [255:0] out_data_q [$];
    logic [31:0]  out_keep_q [$];
    logic         out_last_q [$];

    always #2 clk = ~clk;

    pcie_h2c_dsc_issuer dut (
        .user_clk_250     (clk),
        .user_reset       (user_reset),
        .enable           (enable),
        .dsc_byp_src_addr (dsc_byp_src_addr),
        .dsc_byp_dst_addr (dsc_byp_dst_addr),
        .dsc_byp_len      (dsc_byp_len),
        .dsc_byp_ctl      (dsc_byp_ctl),
        .dsc_byp_load     (dsc_byp_load),
        .dsc_byp_ready    (dsc_byp_ready),
        .s_h2c_tdata      (s_h2c_tdata),
        .s_h2c_tkeep      (s_h2c_tkeep),
        .s_h2c_tlast      (s_h2c_tlast),
        .s_h2c_tvalid     (s_h2c_tvalid),
        .s_h2c_tready     (s_h2c_tready),
        .m_tdata          (m_tdata),
        .m_tkeep          (m_tkeep),
        .m_tlast          (m_tlast),
        .m_tvalid         (m_tvalid),
        .m_tready         (m_tready),
        .nr_issued        (nr_issued),
        .nr_completed     (nr_completed),
        .len_err          (len_err)
    );

    // Handshake recorder; the negedge sees the values the next posedge will sample
    always @(negedge clk) begin
        if (!user_reset) begin
            if (dsc_byp_load && dsc_byp_ready) acc_q.push_back(dsc_byp_src_addr);
            if (s_h2c_tvalid && s_h2c_tready) in_cnt++;
            if (m_tvalid && m_tready) begin
                out_data_q.push_back(m_tdata);
                out_keep_q.push_back(m_tkeep);
                out_last_q.push_back(m_tlast);
                out_cnt++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_records();
        acc_q.delete();
        exp_data_q.delete(); exp_keep_q.delete(); exp_last_q.delete();
        out_data_q.delete(); out_keep_q.delete(); out_last_q.delete();
        in_cnt = 0; out_cnt = 0; stalls = 0;
    endtask

    task automatic do_reset();
        user_reset = 1'b1; enable = 1'b0; dsc_byp_ready = 1'b0;
        s_h2c_tvalid = 1'b0; s_h2c_tlast = 1'b0; s_h2c_tkeep = 32'd0; s_h2c_tdata = 256'd0;
        m_tready = 1'b1; bp_mode = 1'b0;
        step(); step();
        user_reset = 1'b0;
        step();
        clear_records();
    endtask

    task automatic send_beat(input logic [255:0] data, input logic [31:0] keep, input logic last,
                             input logic chk_occ);
        logic rdy;
        logic done;
        done = 1'b0;
        s_h2c_tdata = data; s_h2c_tkeep = keep; s_h2c_tlast = last; s_h2c_tvalid = 1'b1;
        for (int t = 0; t < 64 && !done; t++) begin
            rdy = s_h2c_tready;
            if (chk_occ) begin
                n_tests++;
                if (s_h2c_tready !== ((in_cnt - out_cnt) < 2)) begin
                    n_fail++;
                    $display("FAIL tready_occupancy: got %0b, expected %0b (occupancy %0d)",
                             s_h2c_tready, ((in_cnt - out_cnt) < 2), in_cnt - out_cnt);
                end
            end
            step();
            if (bp_mode) m_tready = ~m_tready;
            if (rdy) begin
                done = 1'b1;
                exp_data_q.push_back(data); exp_keep_q.push_back(keep); exp_last_q.push_back(last);
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: s_h2c_tready stayed 0, expected a handshake within 64 cycles");
        end
    endtask

    task automatic send_packet(input int pkt, input int nbeats, input logic [31:0] last_keep,
                               input logic chk_occ);
        logic [15:0] p;
        logic [15:0] b;
        p = pkt[15:0];
        for (int i = 0; i < nbeats; i++) begin
            b = i[15:0];
            send_beat({8{p, b}}, (i == nbeats - 1) ? last_keep : 32'hFFFF_FFFF,
                      (i == nbeats - 1), chk_occ);
        end
        s_h2c_tvalid = 1'b0; s_h2c_tlast = 1'b0;
    endtask

    task automatic drain();
        s_h2c_tvalid = 1'b0; s_h2c_tlast = 1'b0;
        for (int t = 0; t < 1000 && out_cnt != in_cnt; t++) begin
            step();
            if (bp_mode) m_tready = ~m_tready;
        end
        n_tests++;
        if (out_cnt != in_cnt) begin
            n_fail++;
            $display("FAIL drain: %0d beats out, expected %0d", out_cnt, in_cnt);
        end
        bp_mode = 1'b0; m_tready = 1'b1;
        repeat (6) step();
    endtask

    task automatic check_stream(input string name);
        int bad;
        int first;
        bad = 0; first = -1;
        if (out_data_q.size() != exp_data_q.size()) begin
            bad = 1;
        end else begin
            for (int i = 0; i < exp_data_q.size(); i++) begin
                if (out_data_q[i] !== exp_data_q[i] || out_keep_q[i] !== exp_keep_q[i] ||
                    out_last_q[i] !== exp_last_q[i]) begin
                    bad++;
                    if (first < 0) first = i;
                end
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d beats out with %0d bad (first at %0d), expected %0d beats in order",
                     name, out_data_q.size(), bad, first, exp_data_q.size());
        end
    endtask

    task automatic test_reset();
        user_reset = 1'b1; enable = 1'b1; dsc_byp_ready = 1'b0; m_tready = 1'b1;
        s_h2c_tvalid = 1'b0; s_h2c_tlast = 1'b0; s_h2c_tkeep = 32'd0; s_h2c_tdata = 256'd0;
        step(); step();
        n_tests += 8;
        if (dsc_byp_load !== 1'b0) begin n_fail++; $display("FAIL rst_load: got %0b, expected 0", dsc_byp_load); end
        if (s_h2c_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %0b, expected 0", s_h2c_tready); end
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid: got %0b/%0b, expected 0/0", m_tvalid, m_tlast); end
        if (nr_issued !== 32'd0 || nr_completed !== 32'd0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d, expected 0/0", nr_issued, nr_completed); end
        if (len_err !== 1'b0) begin n_fail++; $display("FAIL rst_len_err: got %0b, expected 0", len_err); end
        if (dsc_byp_dst_addr !== 64'd0) begin n_fail++; $display("FAIL dst_addr: got %h, expected 0", dsc_byp_dst_addr); end
        if (dsc_byp_len !== 28'h000_1000 || dsc_byp_ctl !== 16'h0010) begin n_fail++; $display("FAIL len_ctl: got %h/%h, expected 1000/0010", dsc_byp_len, dsc_byp_ctl); end
        if (dsc_byp_src_addr !== BASE) begin n_fail++; $display("FAIL rst_src: got %h, expected %h", dsc_byp_src_addr, BASE); end
        user_reset = 1'b0;
        step();
        n_tests += 2;
        if (dsc_byp_load !== 1'b1) begin n_fail++; $display("FAIL first_load: got %0b, expected 1 in second cycle after reset", dsc_byp_load); end
        if (s_h2c_tready !== 1'b1) begin n_fail++; $display("FAIL first_tready: got %0b, expected 1", s_h2c_tready); end
    endtask

    task automatic test_basic_issue();
        do_reset();
        enable = 1'b1; dsc_byp_ready = 1'b1;
        repeat (20) step();
        n_tests += 3;
        if (acc_q.size() != 4) begin
            n_fail++; $display("FAIL issue_count: got %0d accepts, expected 4", acc_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (acc_q[i] !== BASE + 64'h1000 * 64'(i)) begin
                    n_fail++; $display("FAIL issue_addr%0d: got %h, expected %h", i, acc_q[i], BASE + 64'h1000 * 64'(i));
                end
            end
        end
        if (dsc_byp_load !== 1'b0) begin n_fail++; $display("FAIL issue_idle_load: got %0b, expected 0", dsc_byp_load); end
        if (nr_issued !== 32'd4) begin n_fail++; $display("FAIL issue_nr_issued: got %0d, expected 4", nr_issued); end
    endtask

    task automatic test_ready_holdoff();
        do_reset();
        enable = 1'b1; dsc_byp_ready = 1'b0;
        for (int t = 0; t < 8 && dsc_byp_load !== 1'b1; t++) step();
        n_tests++;
        if (dsc_byp_load !== 1'b1 || dsc_byp_src_addr !== BASE) begin
            n_fail++; $display("FAIL holdoff_start: load %0b addr %h, expected 1 and %h", dsc_byp_load, dsc_byp_src_addr, BASE);
        end
        for (int t = 0; t < 10; t++) begin
            step();
            n_tests++;
            if (dsc_byp_load !== 1'b1 || dsc_byp_src_addr !== BASE) begin
                n_fail++; $display("FAIL holdoff_hold%0d: load %0b addr %h, expected 1 and %h", t, dsc_byp_load, dsc_byp_src_addr, BASE);
            end
        end
        dsc_byp_ready = 1'b1;
        step();
        dsc_byp_ready = 1'b0;
        n_tests += 3;
        if (acc_q.size() != 1 || acc_q[0] !== BASE) begin n_fail++; $display("FAIL holdoff_accept: %0d accepts, expected 1 at %h", acc_q.size(), BASE); end
        if (dsc_byp_load !== 1'b0) begin n_fail++; $display("FAIL holdoff_wait_load: got %0b, expected 0", dsc_byp_load); end
        step();
        if (dsc_byp_load !== 1'b1 || dsc_byp_src_addr !== BASE + 64'h1000) begin
            n_fail++; $display("FAIL holdoff_next: load %0b addr %h, expected 1 and %h", dsc_byp_load, dsc_byp_src_addr, BASE + 64'h1000);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1; dsc_byp_ready = 1'b0;
        step(); step();
        enable = 1'b0;
        repeat (3) step();
        n_tests += 2;
        if (dsc_byp_load !== 1'b1) begin n_fail++; $display("FAIL endrop_hold: got %0b, expected 1", dsc_byp_load); end
        dsc_byp_ready = 1'b1;
        repeat (6) step();
        if (nr_issued !== 32'd1 || dsc_byp_load !== 1'b0) begin
            n_fail++; $display("FAIL endrop_stop: nr_issued %0d load %0b, expected 1 and 0", nr_issued, dsc_byp_load);
        end
    endtask

    task automatic test_completion_wrap();
        do_reset();
        enable = 1'b1; dsc_byp_ready = 1'b1;
        for (int p = 0; p < 20; p++) send_packet(p, 128, 32'hFFFF_FFFF, 1'b0);
        drain();
        check_stream("wrap_stream");
        n_tests += 5;
        if (stalls != 0) begin n_fail++; $display("FAIL wrap_throughput: %0d stall cycles, expected 0", stalls); end
        if (nr_completed !== 32'd20) begin n_fail++; $display("FAIL wrap_completed: got %0d, expected 20", nr_completed); end
        if (len_err !== 1'b0) begin n_fail++; $display("FAIL wrap_len_err: got %0b, expected 0", len_err); end
        if (nr_issued !== 32'd24) begin n_fail++; $display("FAIL wrap_issued: got %0d, expected 24", nr_issued); end
        if (acc_q.size() < 17 || acc_q[16] !== BASE || acc_q[15] !== BASE + 64'hF000) begin
            n_fail++; $display("FAIL wrap_addr: %0d accepts, 16th/17th not %h/%h", acc_q.size(), BASE + 64'hF000, BASE);
        end
    endtask

    task automatic test_len_error();
        do_reset();
        enable = 1'b1; dsc_byp_ready = 1'b1;
        send_beat({8{32'hC0DE_0000}}, 32'hFFFF_FFFF, 1'b0, 1'b0);
        n_tests += 4;
        if (m_tvalid !== 1'b1 || m_tdata !== {8{32'hC0DE_0000}}) begin
            n_fail++; $display("FAIL latency: m_tvalid %0b data %h, expected beat one cycle after input", m_tvalid, m_tdata[31:0]);
        end
        for (int i = 1; i < 127; i++) send_beat({8{32'hC0DE_0000 + 32'(i)}}, 32'hFFFF_FFFF, 1'b0, 1'b0);
        if (len_err !== 1'b0) begin n_fail++; $display("FAIL lenerr_early: got %0b, expected 0 before tlast", len_err); end
        send_beat({8{32'hC0DE_00FF}}, 32'h0000_FFFF, 1'b1, 1'b0);
        s_h2c_tvalid = 1'b0; s_h2c_tlast = 1'b0;
        if (len_err !== 1'b1) begin n_fail++; $display("FAIL lenerr_set: got %0b, expected 1", len_err); end
        send_packet(7, 128, 32'hFFFF_FFFF, 1'b0);
        drain();
        check_stream("lenerr_stream");
        if (len_err !== 1'b1 || nr_completed !== 32'd2) begin
            n_fail++; $display("FAIL lenerr_sticky: len_err %0b completed %0d, expected 1 and 2", len_err, nr_completed);
        end
    endtask

    task automatic test_orphan_tlast();
        do_reset();
        enable = 1'b0; dsc_byp_ready = 1'b1;
        send_packet(3, 128, 32'hFFFF_FFFF, 1'b0);
        drain();
        n_tests += 2;
        if (len_err !== 1'b1 || nr_issued !== 32'd0) begin
            n_fail++; $display("FAIL orphan_flag: len_err %0b issued %0d, expected 1 and 0", len_err, nr_issued);
        end
        enable = 1'b1;
        repeat (20) step();
        if (nr_issued !== 32'd4) begin n_fail++; $display("FAIL orphan_underflow: issued %0d, expected 4", nr_issued); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        enable = 1'b1; dsc_byp_ready = 1'b1;
        m_tready = 1'b0; bp_mode = 1'b1;
        send_packet(11, 128, 32'hFFFF_FFFF, 1'b1);
        send_packet(12, 128, 32'hFFFF_FFFF, 1'b1);
        drain();
        check_stream("bp_stream");
        n_tests += 2;
        if (stalls == 0) begin n_fail++; $display("FAIL bp_stall: 0 stall cycles, expected back-pressure to reach the input"); end
        if (nr_completed !== 32'd2 || len_err !== 1'b0) begin
            n_fail++; $display("FAIL bp_counts: completed %0d len_err %0b, expected 2 and 0", nr_completed, len_err);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        enable = 1'b1; dsc_byp_ready = 1'b1;
        for (int i = 0; i < 59; i++) send_beat({8{32'hBEEF_0000 + 32'(i)}}, 32'hFFFF_FFFF, 1'b0, 1'b0);
        n_tests += 4;
        if (nr_issued !== 32'd4) begin n_fail++; $display("FAIL midrst_pre: issued %0d, expected 4", nr_issued); end
        s_h2c_tdata = {8{32'hBEEF_003B}}; s_h2c_tvalid = 1'b1; user_reset = 1'b1;
        step();
        if (dsc_byp_load !== 1'b0 || s_h2c_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 ||
            m_tdata !== 256'd0 || m_tkeep !== 32'd0) begin
            n_fail++; $display("FAIL midrst_outputs: load %0b tready %0b tvalid %0b tlast %0b, expected all 0",
                               dsc_byp_load, s_h2c_tready, m_tvalid, m_tlast);
        end
        if (nr_issued !== 32'd0 || nr_completed !== 32'd0 || len_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_counts: %0d/%0d/%0b, expected 0/0/0", nr_issued, nr_completed, len_err);
        end
        user_reset = 1'b0; s_h2c_tvalid = 1'b0;
        clear_records();
        for (int t = 0; t < 10 && acc_q.size() == 0; t++) step();
        if (acc_q.size() == 0 || acc_q[0] !== BASE) begin
            n_fail++; $display("FAIL midrst_addr: %0d accepts, expected first at %h", acc_q.size(), BASE);
        end
        send_packet(21, 128, 32'hFFFF_FFFF, 1'b0);
        drain();
        check_stream("midrst_stream");
        n_tests++;
        if (len_err !== 1'b0 || nr_completed !== 32'd1) begin
            n_fail++; $display("FAIL midrst_clean: len_err %0b completed %0d, expected 0 and 1", len_err, nr_completed);
        end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_ready_holdoff();
        test_enable_drop();
        test_completion_wrap();
        test_len_error();
        test_orphan_tlast();
        test_back_to_back();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
